// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU memory stage and the data memory port.
// Optional store-to-load forwarding is enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wdata,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    output logic [DW-1:0]          cpu_rdata,
    output logic                   cpu_stall,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic                   mem_read,
    output logic                   mem_write,
    input  logic [DW-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0] buf_count,
    output logic                   buf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          is_store;
    logic          is_load;
    logic          full;
    logic          enq;
    logic          drain;
    logic          hit;
    logic          ld_stall;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] idx;

    assign is_store = cpu_write & ~rst;
    assign is_load  = cpu_read & ~cpu_write & ~rst;
    assign full     = (count == CW'(DEPTH));
    assign enq      = is_store & ~full;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && addr_q[idx] == cpu_addr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign mem_read = is_load & ~hit;
    assign drain    = (count != '0) & ~mem_read & ~rst;

`ifdef STORE_BUFFER_FWD_EN
    assign ld_stall  = 1'b0;
    assign cpu_rdata = !is_load ? '0 :
                       hit      ? hit_data : mem_rdata;
`else
    // A matching load waits for the older stores to reach memory.
    assign ld_stall  = is_load & hit;
    assign cpu_rdata = mem_read ? mem_rdata : '0;
`endif

    assign cpu_stall = (is_store & full) | ld_stall;
    assign mem_write = drain;
    assign mem_addr  = mem_read ? cpu_addr     :
                       drain    ? addr_q[head] : '0;
    assign mem_wdata = drain ? data_q[head] : '0;
    assign buf_count = count;
    assign buf_empty = (count == '0);

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= cpu_addr;
            data_q[tail] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            unique case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
